// File: rtl/aurora_tx_arbiter.sv
// Purpose : packet-atomic arbiter sharing the Aurora 8b10b TX AXI-Stream between the host path (src0) and the RX->TX loopback FIFO (src1).
// Latency : 1 cycle of arbitration in IDLE, then a combinational passthrough of the granted source in SEND.
// Backpressure: the granted source sees m_axis_tready directly and the ungranted source is held at tready=0. In DRAIN the granted source is drained with tready=1.
//
// Ports:
//   m_axis_aclk / m_axis_aresetn   user clock, async active-low reset
//   mode[1:0]                      0=src0 only, 1=src1 only, 2=round-robin, 3=src0 fixed priority
//   channel_up                     Aurora channel status (synchronous to m_axis_aclk)
//   s0_axis_* / s1_axis_*          source streams (tvalid/tdata/tlast in, tready out)
//   m_axis_*                       stream to Aurora s_axi_tx_* (tvalid/tdata/tlast out, tready in)
//   pkt_cnt0 / pkt_cnt1            packets completed per source, wrapping
//   drop_cnt                       packets cut by link drop or truncation, saturating
//   busy                           arbiter is not in IDLE
module aurora_tx_arbiter #(
    parameter int DATA_W    = 32,
    parameter int CNT_W     = 16,
    parameter int MAX_BEATS = 64
) (
    input  logic              m_axis_aclk,
    input  logic              m_axis_aresetn,
    input  logic [1:0]        mode,
    input  logic              channel_up,
    input  logic              s0_axis_tvalid,
    input  logic [DATA_W-1:0] s0_axis_tdata,
    input  logic              s0_axis_tlast,
    output logic              s0_axis_tready,
    input  logic              s1_axis_tvalid,
    input  logic [DATA_W-1:0] s1_axis_tdata,
    input  logic              s1_axis_tlast,
    output logic              s1_axis_tready,
    output logic              m_axis_tvalid,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready,
    output logic [CNT_W-1:0]  pkt_cnt0,
    output logic [CNT_W-1:0]  pkt_cnt1,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic              busy
);

    localparam int                BEAT_W    = $clog2(MAX_BEATS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BEATS - 1);

    localparam logic [1:0] MODE_SRC0 = 2'd0;
    localparam logic [1:0] MODE_SRC1 = 2'd1;
    localparam logic [1:0] MODE_RR   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               grant_q, grant_d;
    logic               last_served_q, last_served_d;
    logic [BEAT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0]   pkt_cnt0_q, pkt_cnt0_d;
    logic [CNT_W-1:0]   pkt_cnt1_q, pkt_cnt1_d;
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

    logic               pick_vld;
    logic               pick_src;
    logic               src_vld;
    logic [DATA_W-1:0]  src_dat;
    logic               src_lst;
    logic               src_rdy;
    logic               at_max;
    logic               pkt_inc;
    logic               drop_inc;

    // Granted-source view of the two input streams.
    assign src_vld = grant_q ? s1_axis_tvalid : s0_axis_tvalid;
    assign src_dat = grant_q ? s1_axis_tdata  : s0_axis_tdata;
    assign src_lst = grant_q ? s1_axis_tlast  : s0_axis_tlast;
    assign at_max  = (beat_cnt_q == LAST_BEAT);

    // Requester selection. Only evaluated while IDLE, so a mode change mid-packet
    // takes effect at the next arbitration.
    always_comb begin
        pick_vld = 1'b0;
        pick_src = 1'b0;
        case (mode)
            MODE_SRC0: begin
                pick_vld = s0_axis_tvalid;
                pick_src = 1'b0;
            end
            MODE_SRC1: begin
                pick_vld = s1_axis_tvalid;
                pick_src = 1'b1;
            end
            MODE_RR: begin
                pick_vld = s0_axis_tvalid | s1_axis_tvalid;
                pick_src = (s0_axis_tvalid & s1_axis_tvalid) ? ~last_served_q : s1_axis_tvalid;
            end
            default: begin
                pick_vld = s0_axis_tvalid | s1_axis_tvalid;
                pick_src = ~s0_axis_tvalid;
            end
        endcase
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_served_d = last_served_q;
        beat_cnt_d    = beat_cnt_q;
        pkt_inc       = 1'b0;
        drop_inc      = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tlast  = 1'b0;
        src_rdy       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (channel_up && pick_vld) begin
                    grant_d    = pick_src;
                    beat_cnt_d = '0;
                    state_d    = ST_SEND;
                end
            end

            ST_SEND: begin
                m_axis_tdata = src_dat;
                m_axis_tlast = src_lst | at_max;
                if (!channel_up) begin
                    // Link fell before this beat was taken: hide it from Aurora and
                    // keep the source stalled this cycle. The rest of the packet,
                    // including this beat, is discarded in DRAIN. A tlast beat that
                    // was accepted while the link was still up has already completed.
                    state_d  = ST_DRAIN;
                    drop_inc = 1'b1;
                end else begin
                    m_axis_tvalid = src_vld;
                    src_rdy       = m_axis_tready;
                    if (src_vld && m_axis_tready) begin
                        if (src_lst) begin
                            pkt_inc       = 1'b1;
                            last_served_d = grant_q;
                            beat_cnt_d    = '0;
                            state_d       = ST_IDLE;
                        end else if (at_max) begin
                            // Oversized packet: close it on the wire with a forced
                            // tlast, count it as sent and as cut, then discard the tail.
                            pkt_inc  = 1'b1;
                            drop_inc = 1'b1;
                            state_d  = ST_DRAIN;
                        end else begin
                            beat_cnt_d = beat_cnt_q + 1'b1;
                        end
                    end
                end
            end

            ST_DRAIN: begin
                src_rdy = 1'b1;
                if (src_vld && src_lst) begin
                    last_served_d = grant_q;
                    state_d       = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        pkt_cnt0_d = pkt_cnt0_q;
        pkt_cnt1_d = pkt_cnt1_q;
        drop_cnt_d = drop_cnt_q;
        if (pkt_inc) begin
            if (grant_q) begin
                pkt_cnt1_d = pkt_cnt1_q + 1'b1;
            end else begin
                pkt_cnt0_d = pkt_cnt0_q + 1'b1;
            end
        end
        if (drop_inc && (drop_cnt_q != {CNT_W{1'b1}})) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            state_q       <= ST_IDLE;
            grant_q       <= 1'b0;
            last_served_q <= 1'b1;
            beat_cnt_q    <= '0;
            pkt_cnt0_q    <= '0;
            pkt_cnt1_q    <= '0;
            drop_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_served_q <= last_served_d;
            beat_cnt_q    <= beat_cnt_d;
            pkt_cnt0_q    <= pkt_cnt0_d;
            pkt_cnt1_q    <= pkt_cnt1_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    assign s0_axis_tready = src_rdy & ~grant_q;
    assign s1_axis_tready = src_rdy &  grant_q;
    assign pkt_cnt0       = pkt_cnt0_q;
    assign pkt_cnt1       = pkt_cnt1_q;
    assign drop_cnt       = drop_cnt_q;
    assign busy           = (state_q != ST_IDLE);

endmodule
